decode_stage: RTL and testbench

- RV32I decode stage, directly downstream of the fetch stage.
- Accepts (pc, instruction) pairs over a valid/ready handshake.
- Splits each instruction into register indices, function fields and a sign-extended immediate, and flags illegal encodings.
- Results are registered and presented to the execute stage with a 2-entry skid buffer, so backpressure never drops or duplicates an instruction.

---
 rtl/decode_stage.sv | 171 +++++++++++++++++
 tb/tb_decode_stage.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: splits fetched instructions into fields plus a sign-extended immediate
// and hands them to execute through a 2-entry skid buffer. Define DECODE_PERF_CNT_EN for perf counters.
module decode_stage #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic [DWIDTH-1:0] insn_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o,
    output logic [6:0]        opcode_o,
    output logic [4:0]        rd_o,
    output logic [2:0]        funct3_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [6:0]        funct7_o,
    output logic [31:0]       imm_o,
    output logic              illegal_o
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]       perf_decoded_o,
    output logic [31:0]       perf_illegal_o
`endif
);

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_OP     = 7'b0110011,
        OP_FENCE  = 7'b0001111,
        OP_SYSTEM = 7'b1110011
    } opcode_e;

    // Register fields are plain slices of insn, so only imm and illegal are stored pre-decoded.
    typedef struct packed {
        logic              valid;
        logic [AWIDTH-1:0] pc;
        logic [DWIDTH-1:0] insn;
        logic [31:0]       imm;
        logic              illegal;
    } entry_t;

    entry_t      out_q, out_d;
    entry_t      skid_q, skid_d;
    entry_t      new_entry;
    logic [31:0] dec_imm;
    logic        dec_illegal;
    logic        accept;
    logic        xfer;

    // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        dec_imm     = '0;
        dec_illegal = 1'b0;
        case (insn_i[6:0])
            OP_LOAD, OP_IMM, OP_JALR:
                dec_imm = {{20{insn_i[31]}}, insn_i[31:20]};
            OP_STORE:
                dec_imm = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
            OP_BRANCH:
                dec_imm = {{19{insn_i[31]}}, insn_i[31], insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                dec_imm = {insn_i[31:12], 12'b0};
            OP_JAL:
                dec_imm = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0};
            OP_OP, OP_FENCE, OP_SYSTEM:
                dec_imm = '0;
            default:
                dec_illegal = 1'b1;
        endcase
        if (insn_i[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
            dec_imm     = '0;
        end
    end

    assign new_entry = '{valid: 1'b1, pc: pc_i, insn: insn_i, imm: dec_imm, illegal: dec_illegal};

    assign in_ready_o  = !skid_q.valid;
    assign out_valid_o = out_q.valid;
    assign accept      = in_valid_i && in_ready_o;
    assign xfer        = out_q.valid && out_ready_i;

    always_comb begin
        out_d  = out_q;
        skid_d = skid_q;
        if (flush_i) begin
            out_d.valid  = 1'b0;
            skid_d.valid = 1'b0;
        end else if (!out_q.valid || xfer) begin
            // in_ready_o is low while SKID is full, so draining SKID never races an accept.
            if (skid_q.valid) begin
                out_d        = skid_q;
                skid_d.valid = 1'b0;
            end else if (accept) begin
                out_d = new_entry;
            end else begin
                out_d.valid = 1'b0;
            end
        end else if (accept) begin
            skid_d = new_entry;
        end
    end

    // NOTE: data fields are reset along with the valid bits because the data outputs must read 0 in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            out_q  <= out_d;
            skid_q <= skid_d;
        end
    end

    assign pc_o      = out_q.pc;
    assign insn_o    = out_q.insn;
    assign opcode_o  = out_q.insn[6:0];
    assign rd_o      = out_q.insn[11:7];
    assign funct3_o  = out_q.insn[14:12];
    assign rs1_o     = out_q.insn[19:15];
    assign rs2_o     = out_q.insn[24:20];
    assign funct7_o  = out_q.insn[31:25];
    assign imm_o     = out_q.imm;
    assign illegal_o = out_q.illegal;

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] perf_decoded_q, perf_decoded_d;
    logic [31:0] perf_illegal_q, perf_illegal_d;

    // A transfer in a flush cycle still reaches execute, so it is counted; flush never clears these.
    always_comb begin
        perf_decoded_d = perf_decoded_q;
        perf_illegal_d = perf_illegal_q;
        if (xfer) begin
            perf_decoded_d = perf_decoded_q + 32'd1;
            if (out_q.illegal) begin
                perf_illegal_d = perf_illegal_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_decoded_q <= '0;
            perf_illegal_q <= '0;
        end else begin
            perf_decoded_q <= perf_decoded_d;
            perf_illegal_q <= perf_illegal_d;
        end
    end

    assign perf_decoded_o = perf_decoded_q;
    assign perf_illegal_o = perf_illegal_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: decode fields, immediates, illegal detection,
// skid-buffer backpressure, flush and asynchronous reset. Honours DECODE_PERF_CNT_EN.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] pc_i;
    logic [31:0] insn_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] pc_o;
    logic [31:0] insn_o;
    logic [6:0]  opcode_o;
    logic [4:0]  rd_o;
    logic [2:0]  funct3_o;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
    logic [6:0]  funct7_o;
    logic [31:0] imm_o;
    logic        illegal_o;
`ifdef DECODE_PERF_CNT_EN
    logic [31:0] perf_decoded_o;
    logic [31:0] perf_illegal_o;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    decode_stage #(.DWIDTH(32), .AWIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .pc_i(pc_i), .insn_i(insn_i), .flush_i(flush_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .pc_o(pc_o), .insn_o(insn_o), .opcode_o(opcode_o), .rd_o(rd_o),
        .funct3_o(funct3_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .funct7_o(funct7_o),
        .imm_o(imm_o), .illegal_o(illegal_o)
`ifdef DECODE_PERF_CNT_EN
        , .perf_decoded_o(perf_decoded_o), .perf_illegal_o(perf_illegal_o)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid_i = 1'b0; pc_i = '0; insn_i = '0; flush_i = 1'b0; out_ready_i = 1'b0;
        step();
        compared++; if (out_valid_o !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b want 0", out_valid_o); end
        compared++; if (in_ready_o !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready: got %b want 1", in_ready_o); end
        compared++; if (pc_o !== 32'h0 || insn_o !== 32'h0 || imm_o !== 32'h0 || illegal_o !== 1'b0) begin
            mismatched++; $display("FAIL reset_data: got pc=%h insn=%h imm=%h ill=%b want all 0", pc_o, insn_o, imm_o, illegal_o);
        end
        rst = 1'b1;
        step();
        compared++; if (out_valid_o !== 1'b0) begin mismatched++; $display("FAIL post_reset_idle: got %b want 0", out_valid_o); end
    endtask

    task automatic test_basic();
        out_ready_i = 1'b1; in_valid_i = 1'b1; pc_i = 32'h0100_0000; insn_i = 32'h0050_0093;
        step();
        in_valid_i = 1'b0;
        compared++; if (out_valid_o !== 1'b1) begin mismatched++; $display("FAIL basic_valid: got %b want 1", out_valid_o); end
        compared++; if (pc_o !== 32'h0100_0000) begin mismatched++; $display("FAIL basic_pc: got %h want 01000000", pc_o); end
        compared++; if (rd_o !== 5'd1 || rs1_o !== 5'd0 || funct3_o !== 3'd0 || opcode_o !== 7'h13) begin
            mismatched++; $display("FAIL basic_fields: got rd=%0d rs1=%0d f3=%0d op=%h want 1 0 0 13", rd_o, rs1_o, funct3_o, opcode_o);
        end
        compared++; if (imm_o !== 32'h5 || illegal_o !== 1'b0) begin
            mismatched++; $display("FAIL basic_imm: got imm=%h ill=%b want 00000005 0", imm_o, illegal_o);
        end
        compared++; if (insn_o !== 32'h0050_0093) begin mismatched++; $display("FAIL basic_insn: got %h want 00500093", insn_o); end
        step();
        compared++; if (out_valid_o !== 1'b0) begin mismatched++; $display("FAIL basic_drain: got %b want 0", out_valid_o); end
        // sub x3,x1,x2
        in_valid_i = 1'b1; pc_i = 32'h0100_0004; insn_i = 32'h4020_81B3;
        step();
        in_valid_i = 1'b0;
        compared++; if (rd_o !== 5'd3 || rs1_o !== 5'd1 || rs2_o !== 5'd2 || funct7_o !== 7'h20 || opcode_o !== 7'h33 || imm_o !== 32'h0) begin
            mismatched++; $display("FAIL rtype_fields: got rd=%0d rs1=%0d rs2=%0d f7=%h op=%h imm=%h want 3 1 2 20 33 0",
                                   rd_o, rs1_o, rs2_o, funct7_o, opcode_o, imm_o);
        end
        step();
    endtask

    // Presented back to back with out_ready high, so this also exercises 1 insn/cycle throughput.
    task automatic test_immediates();
        logic [31:0] v_insn [15];
        logic [31:0] v_imm  [15];
        logic [4:0]  v_rd   [15];
        logic        v_ill  [15];
        v_insn = '{32'hFE00_0CE3, 32'h1234_52B7, 32'h0080_006F, 32'hFFF0_0093, 32'hFE20_AE23,
                   32'h0000_1297, 32'h0020_81B3, 32'h0000_0073, 32'h0FF0_000F, 32'h8000_A283,
                   32'h0000_8067, 32'hFFDF_F0EF, 32'h0020_8863, 32'h0000_0000, 32'h0000_007F};
        v_imm  = '{32'hFFFF_FFF8, 32'h1234_5000, 32'h0000_0008, 32'hFFFF_FFFF, 32'hFFFF_FFFC,
                   32'h0000_1000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_F800,
                   32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000};
        v_rd   = '{5'd25, 5'd5, 5'd0, 5'd1, 5'd28, 5'd5, 5'd3, 5'd0, 5'd0, 5'd5, 5'd0, 5'd1, 5'd16, 5'd0, 5'd0};
        v_ill  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        out_ready_i = 1'b1;
        for (int i = 0; i < 15; i++) begin
            in_valid_i = 1'b1; pc_i = 32'h2000 + 32'(i * 4); insn_i = v_insn[i];
            compared++; if (in_ready_o !== 1'b1) begin mismatched++; $display("FAIL imm_ready[%0d]: got %b want 1", i, in_ready_o); end
            step();
            compared++; if (out_valid_o !== 1'b1 || pc_o !== 32'h2000 + 32'(i * 4)) begin
                mismatched++; $display("FAIL imm_out[%0d]: got v=%b pc=%h want 1 %h", i, out_valid_o, pc_o, 32'h2000 + 32'(i * 4));
            end
            compared++; if (imm_o !== v_imm[i]) begin mismatched++; $display("FAIL imm_value[%0d]: got %h want %h", i, imm_o, v_imm[i]); end
            compared++; if (rd_o !== v_rd[i]) begin mismatched++; $display("FAIL imm_rd[%0d]: got %0d want %0d", i, rd_o, v_rd[i]); end
            compared++; if (illegal_o !== v_ill[i]) begin mismatched++; $display("FAIL imm_illegal[%0d]: got %b want %b", i, illegal_o, v_ill[i]); end
        end
        // Valid-looking opcode bits but insn[1:0] = 00.
        insn_i = 32'h0050_0090; pc_i = 32'h3000;
        step();
        in_valid_i = 1'b0;
        compared++; if (illegal_o !== 1'b1 || imm_o !== 32'h0) begin
            mismatched++; $display("FAIL illegal_lowbits: got ill=%b imm=%h want 1 00000000", illegal_o, imm_o);
        end
        step();
    endtask

    task automatic test_backpressure();
        logic exp_rdy [5];
        int   in_idx  = 0;
        int   out_idx = 0;
        logic acc;
        exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 20; k++) begin
            out_ready_i = (k >= 3);
            in_valid_i  = (in_idx < 4);
            pc_i        = 32'h100 + 32'(in_idx * 4);
            insn_i      = 32'h0000_0013 | (32'(in_idx) << 7);
            if (k < 5) begin
                compared++; if (in_ready_o !== exp_rdy[k]) begin
                    mismatched++; $display("FAIL bp_ready[cycle %0d]: got %b want %b", k, in_ready_o, exp_rdy[k]);
                end
            end
            if (out_valid_o && out_ready_i) begin
                compared++; if (out_idx >= 4 || pc_o !== 32'h100 + 32'(out_idx * 4) || rd_o !== 5'(out_idx)) begin
                    mismatched++; $display("FAIL bp_order[%0d]: got pc=%h rd=%0d want pc=%h rd=%0d", out_idx, pc_o, rd_o,
                                           32'h100 + 32'(out_idx * 4), out_idx);
                end
                out_idx++;
            end
            acc = in_valid_i && in_ready_o;
            step();
            if (acc) in_idx++;
        end
        in_valid_i = 1'b0;
        compared++; if (out_idx !== 4 || in_idx !== 4) begin
            mismatched++; $display("FAIL bp_count: got in=%0d out=%0d want 4 4", in_idx, out_idx);
        end
    endtask

    task automatic test_flush();
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; pc_i = 32'h200; insn_i = 32'h0000_0013;
        step();
        pc_i = 32'h204;
        step();
        compared++; if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0) begin
            mismatched++; $display("FAIL flush_prefill: got v=%b rdy=%b want 1 0", out_valid_o, in_ready_o);
        end
        flush_i = 1'b1; pc_i = 32'h208;
        step();
        flush_i = 1'b0; in_valid_i = 1'b0;
        compared++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            mismatched++; $display("FAIL flush_full: got v=%b rdy=%b want 0 1", out_valid_o, in_ready_o);
        end
        step();
        compared++; if (out_valid_o !== 1'b0) begin mismatched++; $display("FAIL flush_full_absent: got %b want 0", out_valid_o); end
        // SKID empty: without the flush this input would have been accepted into SKID.
        in_valid_i = 1'b1; pc_i = 32'h300;
        step();
        flush_i = 1'b1; pc_i = 32'h304;
        compared++; if (in_ready_o !== 1'b1) begin mismatched++; $display("FAIL flush_half_ready: got %b want 1", in_ready_o); end
        step();
        flush_i = 1'b0; in_valid_i = 1'b0;
        compared++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            mismatched++; $display("FAIL flush_half: got v=%b rdy=%b want 0 1", out_valid_o, in_ready_o);
        end
        step();
        compared++; if (out_valid_o !== 1'b0) begin mismatched++; $display("FAIL flush_half_absent: got %b want 0", out_valid_o); end
        in_valid_i = 1'b1; pc_i = 32'h30C; out_ready_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        compared++; if (out_valid_o !== 1'b1 || pc_o !== 32'h30C) begin
            mismatched++; $display("FAIL flush_recover: got v=%b pc=%h want 1 0000030c", out_valid_o, pc_o);
        end
        step();
    endtask

    task automatic test_reset_midstream();
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; pc_i = 32'h400; insn_i = 32'hFFF0_0093;
        step();
        pc_i = 32'h404;
        step();
        compared++; if (out_valid_o !== 1'b1 || imm_o !== 32'hFFFF_FFFF) begin
            mismatched++; $display("FAIL rstmid_prefill: got v=%b imm=%h want 1 ffffffff", out_valid_o, imm_o);
        end
        #2;
        rst = 1'b0;
        #1;
        compared++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            mismatched++; $display("FAIL rstmid_handshake: got v=%b rdy=%b want 0 1", out_valid_o, in_ready_o);
        end
        compared++; if (pc_o !== 32'h0 || insn_o !== 32'h0 || imm_o !== 32'h0 || rd_o !== 5'd0 || illegal_o !== 1'b0) begin
            mismatched++; $display("FAIL rstmid_data: got pc=%h insn=%h imm=%h rd=%0d ill=%b want all 0", pc_o, insn_o, imm_o, rd_o, illegal_o);
        end
`ifdef DECODE_PERF_CNT_EN
        compared++; if (perf_decoded_o !== 32'h0 || perf_illegal_o !== 32'h0) begin
            mismatched++; $display("FAIL rstmid_perf: got dec=%0d ill=%0d want 0 0", perf_decoded_o, perf_illegal_o);
        end
`endif
        step();
        in_valid_i = 1'b0;
        rst = 1'b1;
        step();
        compared++; if (out_valid_o !== 1'b0) begin mismatched++; $display("FAIL rstmid_release: got %b want 0", out_valid_o); end
    endtask

`ifdef DECODE_PERF_CNT_EN
    task automatic test_perf();
        logic [31:0] p_insn [3];
        p_insn = '{32'h0050_0093, 32'h0000_0000, 32'h0050_0093};
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1; pc_i = 32'h500 + 32'(i * 4); insn_i = p_insn[i];
            step();
        end
        in_valid_i = 1'b0;
        step();
        compared++; if (perf_decoded_o !== 32'd3 || perf_illegal_o !== 32'd1) begin
            mismatched++; $display("FAIL perf_counts: got dec=%0d ill=%0d want 3 1", perf_decoded_o, perf_illegal_o);
        end
        // Flush must leave the counters alone.
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        compared++; if (perf_decoded_o !== 32'd3 || perf_illegal_o !== 32'd1) begin
            mismatched++; $display("FAIL perf_flush: got dec=%0d ill=%0d want 3 1", perf_decoded_o, perf_illegal_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_immediates();
        test_backpressure();
        test_flush();
        test_reset_midstream();
`ifdef DECODE_PERF_CNT_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
